// File: rtl/axis_rr_arbiter_8to1.sv
// Packet-aware round-robin arbiter: eight AXI-Stream sources share one sink.
// The grant is held from the first beat to the accepted tlast beat.
module axis_rr_arbiter_8to1 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*WIDTH-1:0]   s_data,
    input  logic [7:0]           s_valid,
    input  logic [7:0]           s_last,
    output logic [7:0]           s_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    input  logic [7:0]           src_mask,
    output logic                 grant_valid,
    output logic [2:0]           grant_idx,
    output logic [CNT_W-1:0]     beat_cnt,
    output logic [CNT_W-1:0]     pkt_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       last_grant;
    logic [7:0]       req;
    logic             rr_found;
    logic [2:0]       rr_winner;
    logic             accept;
    logic [WIDTH-1:0] src_data [8];

    // First set bit of r scanning upward from last+1, wrapping; MSB = found.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = last + 3'(k);
            if (!res[3] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    for (genvar i = 0; i < 8; i++) begin : g_unpack
        assign src_data[i] = s_data[i*WIDTH +: WIDTH];
    end

    assign req = s_valid & src_mask;
    assign {rr_found, rr_winner} = rr_pick(req, last_grant);

    always_comb begin
        state_nxt = state;
        s_ready   = '0;
        m_data    = '0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                m_data             = src_data[grant_idx];
                m_valid            = s_valid[grant_idx];
                m_last             = s_last[grant_idx];
                s_ready[grant_idx] = m_ready;
                accept             = m_valid & m_ready;
                if (accept && m_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Reset blanks the handshake at once so a mid-packet beat is never accepted.
        if (!rst_n) begin
            state_nxt = IDLE;
            s_ready   = '0;
            m_data    = '0;
            m_valid   = 1'b0;
            m_last    = 1'b0;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= 3'd0;
            last_grant  <= 3'd7;
            beat_cnt    <= '0;
            pkt_cnt     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        grant_idx   <= rr_winner;
                        last_grant  <= rr_winner;
                        grant_valid <= 1'b1;
                        beat_cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        beat_cnt <= sat_inc(beat_cnt);
                        if (m_last) begin
                            grant_valid <= 1'b0;
                            pkt_cnt     <= pkt_cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter_8to1.sv
// Bench for axis_rr_arbiter_8to1: per-source beat queues drive the inputs and
// a scoreboard of expected (source, last, data) beats is checked at the sink.
module tb_axis_rr_arbiter_8to1;

    localparam int WIDTH = 16;
    localparam int CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [8*WIDTH-1:0]   s_data;
    logic [7:0]           s_valid;
    logic [7:0]           s_last;
    logic [7:0]           s_ready;
    logic [WIDTH-1:0]     m_data;
    logic                 m_valid;
    logic                 m_last;
    logic                 m_ready;
    logic [7:0]           src_mask;
    logic                 grant_valid;
    logic [2:0]           grant_idx;
    logic [CNT_W-1:0]     beat_cnt;
    logic [CNT_W-1:0]     pkt_cnt;

    always #5 clk = ~clk;

    axis_rr_arbiter_8to1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .src_mask(src_mask), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt)
    );

    logic [WIDTH:0] mem [8][64];
    int             head [8];
    int             tail [8];
    logic [19:0]    exp_q [$];
    int             n_checks = 0;
    int             n_errors = 0;
    logic [7:0]     acc = 8'h00;
    logic           rst_req = 1'b0;
    logic           bp = 1'b0;
    int             seq = 0;
    logic           any_grant;
    logic           seen_rdy0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // nexp = how many leading beats of this packet the sink is expected to see.
    task automatic add_pkt(input int src, input int nb, input int nexp);
        logic [WIDTH-1:0] d;
        logic             lst;
        for (int b = 0; b < nb; b++) begin
            d   = WIDTH'(src * 4096 + seq);
            seq++;
            lst = (b == nb - 1);
            mem[src][tail[src]] = {lst, d};
            tail[src]++;
            if (b < nexp) exp_q.push_back({3'(src), lst, d});
        end
    endtask

    task automatic flush(input int src);
        head[src] = 0;
        tail[src] = 0;
        acc[src]  = 1'b0;
    endtask

    task automatic drive();
        logic [WIDTH:0] e;
        for (int i = 0; i < 8; i++) begin
            if (head[i] < tail[i]) begin
                e = mem[i][head[i]];
                s_valid[i] = 1'b1;
                s_last[i]  = e[WIDTH];
                s_data[i*WIDTH +: WIDTH] = e[WIDTH-1:0];
            end else begin
                s_valid[i] = 1'b0;
                s_last[i]  = 1'b0;
                s_data[i*WIDTH +: WIDTH] = '0;
            end
        end
    endtask

    task automatic monitor();
        logic [7:0]  exp_rdy;
        logic [19:0] e;
        exp_rdy = (rst_n && grant_valid && m_ready) ? (8'h01 << grant_idx) : 8'h00;
        check_val("s_ready", s_ready, exp_rdy);
        acc = s_valid & s_ready;
        if (m_valid && m_ready) begin
            check_val("accept_one_hot", acc, 8'h01 << grant_idx);
            if (exp_q.size() == 0) begin
                check_val("unexpected_beat_qsize", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_val("beat_src_last_data", {grant_idx, m_last, m_data}, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) if (acc[i]) head[i]++;
        rst_n = rst_req;
        if (bp) m_ready = ~m_ready;
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || grant_valid) && n < budget) begin
            step();
            n++;
        end
        check_val("done_in_budget", n < budget, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        m_ready  = 1'b1;
        src_mask = 8'hFF;
        s_valid  = '0;
        s_last   = '0;
        s_data   = '0;
        for (int i = 0; i < 8; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        drive();
        @(negedge clk);
        repeat (3) step();
        check_val("rst_grant_valid", grant_valid, 0);
        check_val("rst_grant_idx", grant_idx, 0);
        check_val("rst_beat_cnt", beat_cnt, 0);
        check_val("rst_pkt_cnt", pkt_cnt, 0);
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_m_data", m_data, 0);
        rst_req = 1'b1;
        step();

        // single source, 3-beat packet
        add_pkt(2, 3, 3);
        step();
        check_val("t1_no_grant_before_arb", grant_valid, 0);
        step();
        check_val("t1_grant_idx", grant_idx, 2);
        check_val("t1_grant_valid", grant_valid, 1);
        check_val("t1_s_ready", s_ready, 8'h04);
        step();
        check_val("t1_beat_cnt_1", beat_cnt, 1);
        wait_done(20);
        check_val("t1_beat_cnt", beat_cnt, 3);
        check_val("t1_pkt_cnt", pkt_cnt, 1);
        check_val("t1_grant_valid_end", grant_valid, 0);

        // round-robin from reset over all eight sources
        rst_req = 1'b0;
        step();
        rst_req = 1'b1;
        step();
        for (int i = 0; i < 8; i++) add_pkt(i, 1, 1);
        add_pkt(0, 1, 1);
        repeat (18) step();
        check_val("t2_pkt_cnt_8", pkt_cnt, 8);
        step();
        check_val("t2_pkt_cnt_9", pkt_cnt, 9);
        wait_done(10);

        // backpressure on source 5
        add_pkt(5, 4, 4);
        bp = 1'b1;
        wait_done(40);
        bp = 1'b0;
        m_ready = 1'b1;
        check_val("t3_beat_cnt", beat_cnt, 4);
        check_val("t3_pkt_cnt", pkt_cnt, 10);

        // mask: source 0 disabled, then source 1 disabled mid-packet
        src_mask = 8'hFE;
        add_pkt(0, 2, 0);
        add_pkt(1, 3, 3);
        step();
        step();
        check_val("t4_grant_idx", grant_idx, 1);
        check_val("t4_grant_valid", grant_valid, 1);
        src_mask = 8'hFC;
        wait_done(20);
        check_val("t4_pkt_cnt", pkt_cnt, 11);
        add_pkt(1, 1, 0);
        any_grant = 1'b0;
        seen_rdy0 = 1'b0;
        repeat (10) begin
            step();
            if (grant_valid) any_grant = 1'b1;
            if (s_ready[0]) seen_rdy0 = 1'b1;
        end
        check_val("t4_no_regrant", any_grant, 0);
        check_val("t4_src0_never_ready", seen_rdy0, 0);
        flush(0);
        flush(1);
        src_mask = 8'hFF;
        drive();

        // pointer wrap: last grant 7, then sources 0 and 7 both request
        add_pkt(7, 1, 1);
        wait_done(20);
        add_pkt(0, 1, 1);
        add_pkt(7, 1, 1);
        step();
        step();
        check_val("t5_wrap_grant0", grant_idx, 0);
        wait_done(20);

        // reset during beat 2 of source 3
        add_pkt(3, 4, 1);
        step();
        step();
        check_val("t6_grant_idx", grant_idx, 3);
        rst_req = 1'b0;
        step();
        check_val("t6_rst_s_ready", s_ready, 0);
        rst_req = 1'b1;
        step();
        check_val("t6_grant_valid", grant_valid, 0);
        check_val("t6_s_ready", s_ready, 0);
        check_val("t6_pkt_cnt", pkt_cnt, 0);
        check_val("t6_beat_cnt", beat_cnt, 0);
        flush(3);
        add_pkt(0, 1, 1);
        add_pkt(3, 1, 1);
        drive();
        step();
        check_val("t6_next_grant0", grant_idx, 0);
        wait_done(20);
        check_val("t6_pkt_cnt_end", pkt_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
